// File: rtl/softmax_pkg.sv
// Shared types, widths and helpers for the softmax sequencer.
package softmax_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int X_W    = 17;
  localparam int EXP_W  = 21;
  localparam int POS_W  = 5;
  localparam int MANT_W = 16;
  localparam int LIN_W  = 32;

  localparam logic [3:0]       X_INT_MAX = 4'd10;
  localparam logic [POS_W-1:0] POS_CLAMP = 5'd16;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic           clamp;
  } san_t;

  // Clamp oversized magnitudes and turn "negative zero-integer" inputs into 0.
  function automatic san_t sanitise(input logic [X_W-1:0] x);
    san_t r;
    if (x[15:12] > X_INT_MAX) begin
      r.x     = {x[16], X_INT_MAX, 12'd0};
      r.clamp = 1'b1;
    end else if (x[16] && (x[15:12] == 4'd0)) begin
      r.x     = '0;
      r.clamp = 1'b1;
    end else begin
      r.x     = x;
      r.clamp = 1'b0;
    end
    return r;
  endfunction

  // Linearise an exp result: mantissa shifted by its position, position capped at 16.
  function automatic logic [LIN_W-1:0] lin_term(input logic [EXP_W-1:0] r);
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] sh;
    pos = r[EXP_W-1:MANT_W];
    sh  = (pos > POS_CLAMP) ? POS_CLAMP : pos;
    return {{(LIN_W-MANT_W){1'b0}}, r[MANT_W-1:0]} << sh;
  endfunction

endpackage

// File: rtl/softmax_seq_ctrl_if.sv
// Bundle of input stream, exp datapath link, output stream and status.
// master: the sequencer; slave: its environment (source, exp unit, sink).
interface softmax_seq_ctrl_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 7
);
  import softmax_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [X_W-1:0]   in_x;
  logic             in_last;
  logic [X_W-1:0]   exp_x;
  logic [EXP_W-1:0] exp_res;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] out_exp;
  logic             out_last;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic [CNT_W-1:0] count;
  logic             clamp_flag;
  logic             ovf_flag;
  logic             busy;

  modport master (
    input  in_valid, in_x, in_last, exp_res, out_ready,
    output in_ready, exp_x, out_valid, out_exp, out_last,
           sum, sum_valid, count, clamp_flag, ovf_flag, busy
  );

  modport slave (
    output in_valid, in_x, in_last, exp_res, out_ready,
    input  in_ready, exp_x, out_valid, out_exp, out_last,
           sum, sum_valid, count, clamp_flag, ovf_flag, busy
  );

endinterface

// File: rtl/softmax_res_buf.sv
// Result buffer: one write port, one combinational read port.
module softmax_res_buf
  import softmax_pkg::*;
#(
  parameter int MAX_N = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [EXP_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [EXP_W-1:0] rdata_o
);

  logic [EXP_W-1:0] mem_q [MAX_N];

  // Store captured exp results; contents are only read after a full vector is written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencer: issues one vector through the exp unit, buffers and sums
// the results, then streams them out together with the final sum.
module softmax_seq_ctrl #(
  parameter int MAX_N   = 64,
  parameter int EXP_LAT = 1,
  parameter int ACC_W   = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  softmax_seq_ctrl_if.master bus
);
  import softmax_pkg::*;

  localparam int CNT_W = $clog2(MAX_N) + 1;
  localparam int AW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_N);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [AW-1:0]    ONE_AW  = AW'(1);

  state_e           state_q, state_d;
  logic [X_W-1:0]   exp_x_q;
  logic [EXP_LAT:0] vld_q;
  logic [CNT_W-1:0] count_q, rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [ACC_W-1:0] sum_q;
  logic             clamp_q, ovf_q;

  san_t             san_s;
  logic             in_ready_s, accept_s, first_s, vec_end_s, ovf_set_s, capture_s;
  logic             out_valid_s, out_last_s, out_hs_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic [EXP_W-1:0] rd_data_s;

  assign san_s       = sanitise(bus.in_x);
  assign in_ready_s  = (state_q == ST_IDLE) || (state_q == ST_ISSUE);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign first_s     = accept_s && (state_q == ST_IDLE);
  assign cnt_next_s  = first_s ? ONE_CNT : (count_q + ONE_CNT);
  assign vec_end_s   = accept_s && (bus.in_last || (cnt_next_s == MAX_CNT));
  assign ovf_set_s   = accept_s && !bus.in_last && (cnt_next_s == MAX_CNT);
  assign capture_s   = vld_q[EXP_LAT];
  assign out_valid_s = (state_q == ST_OUT) && (rd_ptr_q < count_q);
  assign out_last_s  = out_valid_s && (rd_ptr_q == (count_q - ONE_CNT));
  assign out_hs_s    = out_valid_s && bus.out_ready;

  // Next-state logic for the issue / drain / output sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ISSUE: begin
        if (vec_end_s) begin
          state_d = ST_DRAIN;
        end else if (accept_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (vld_q == '0) begin
          state_d = ST_OUT;
        end else begin
          state_d = state_q;
        end
      end
      ST_OUT: begin
        if (out_hs_s && out_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue pipeline: one valid bit per element in flight through the exp unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept_s;
      for (int i = 1; i <= EXP_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Operand, count and sticky flags; the first element of a vector restarts them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_x_q <= '0;
      count_q <= '0;
      clamp_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept_s) begin
      exp_x_q <= san_s.x;
      count_q <= cnt_next_s;
      clamp_q <= san_s.clamp || (clamp_q && !first_s);
      ovf_q   <= ovf_set_s || (ovf_q && !first_s);
    end
  end

  // Result capture into the buffer and the linear sum; read pointer for streaming out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sum_q    <= '0;
    end else if (first_s) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sum_q    <= '0;
    end else begin
      if (capture_s) begin
        wr_ptr_q <= wr_ptr_q + ONE_AW;
        sum_q    <= sum_q + ACC_W'(lin_term(bus.exp_res));
      end
      if (out_hs_s) begin
        rd_ptr_q <= rd_ptr_q + ONE_CNT;
      end
    end
  end

  softmax_res_buf #(
    .MAX_N (MAX_N),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (capture_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.exp_res),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data_s)
  );

  assign bus.in_ready   = in_ready_s;
  assign bus.exp_x      = exp_x_q;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_exp    = out_valid_s ? rd_data_s : '0;
  assign bus.out_last   = out_last_s;
  assign bus.sum        = sum_q;
  assign bus.sum_valid  = (state_q == ST_OUT);
  assign bus.count      = count_q;
  assign bus.clamp_flag = clamp_q;
  assign bus.ovf_flag   = ovf_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl with a registered exp-unit model.
module tb_softmax_seq_ctrl;
  import softmax_pkg::*;

  localparam int MAX_N   = 4;
  localparam int EXP_LAT = 1;
  localparam int ACC_W   = 40;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_seq_ctrl_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  softmax_seq_ctrl #(
    .MAX_N   (MAX_N),
    .EXP_LAT (EXP_LAT),
    .ACC_W   (ACC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Exp unit model: one register stage; optionally adds the operand to the base result.
  logic [EXP_W-1:0] model_res;
  logic             model_add;
  always @(posedge clk) begin
    bus.exp_res <= model_add ? (model_res + {4'd0, bus.exp_x}) : model_res;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [16:0] x;
    logic [20:0] res;
    logic [16:0] exp_x;
    logic        clamp;
    logic [39:0] sum;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [16:0] x, input logic last);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_sum_valid(input string name);
    int n = 0;
    while (bus.sum_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_sum_valid"}, bus.sum_valid, 1'b1);
  endtask

  // Drain n results with out_ready held high; all results are expected equal to res.
  task automatic drain(input string name, input int n, input logic [20:0] res);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({name, "_out_valid"}, bus.out_valid, 1'b1);
      check({name, "_out_exp"}, bus.out_exp, res);
      check({name, "_out_last"}, bus.out_last, (i == n - 1));
      tick();
    end
    bus.out_ready = 1'b0;
    check({name, "_idle_busy"}, bus.busy, 1'b0);
    check({name, "_idle_sum_valid"}, bus.sum_valid, 1'b0);
    check({name, "_idle_out_valid"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat;
    int got;
    int accepted;

    bus.in_valid  = 1'b0;
    bus.in_x      = 17'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_res     = {5'd1, 16'h8000};
    model_add     = 1'b0;

    tbl[0]  = '{17'h00000, 21'h018000, 17'h00000, 1'b0, 40'h10000};
    tbl[1]  = '{17'h0F000, 21'h018000, 17'h0A000, 1'b1, 40'h10000};
    tbl[2]  = '{17'h10800, 21'h018000, 17'h00000, 1'b1, 40'h10000};
    tbl[3]  = '{17'h1F123, 21'h018000, 17'h1A000, 1'b1, 40'h10000};
    tbl[4]  = '{17'h13456, 21'h018000, 17'h13456, 1'b0, 40'h10000};
    tbl[5]  = '{17'h0A0FF, 21'h018000, 17'h0A0FF, 1'b0, 40'h10000};
    tbl[6]  = '{17'h10000, 21'h018000, 17'h00000, 1'b1, 40'h10000};
    tbl[7]  = '{17'h00000, 21'h140001, 17'h00000, 1'b0, 40'h10000};
    tbl[8]  = '{17'h00000, 21'h110001, 17'h00000, 1'b0, 40'h10000};
    tbl[9]  = '{17'h00000, 21'h10FFFF, 17'h00000, 1'b0, 40'hFFFF0000};
    tbl[10] = '{17'h00000, 21'h001234, 17'h00000, 1'b0, 40'h1234};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_exp_x", bus.exp_x, 17'h0);
    check("rst_sum", bus.sum, 40'h0);
    check("rst_count", bus.count, 3'd0);
    check("rst_clamp", bus.clamp_flag, 1'b0);
    check("rst_ovf", bus.ovf_flag, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_out_exp", bus.out_exp, 21'h0);
    check("rst_sum_valid", bus.sum_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-element vectors from the table
    for (int i = 0; i < 11; i++) begin
      model_res = tbl[i].res;
      check("vec_in_ready_idle", bus.in_ready, 1'b1);
      send(tbl[i].x, 1'b1);
      check("vec_exp_x", bus.exp_x, tbl[i].exp_x);
      check("vec_clamp", bus.clamp_flag, tbl[i].clamp);
      check("vec_count", bus.count, 3'd1);
      check("vec_in_ready_drain", bus.in_ready, 1'b0);
      check("vec_busy", bus.busy, 1'b1);
      wait_sum_valid("vec");
      check("vec_sum", bus.sum, tbl[i].sum);
      drain("vec", 1, tbl[i].res);
    end

    // Four distinct elements with an input gap, then a stalled output stream
    model_res = {5'd1, 16'h8000};
    model_add = 1'b1;
    send(17'h00001, 1'b0);
    send(17'h00002, 1'b0);
    tick();
    send(17'h00003, 1'b0);
    send(17'h00004, 1'b1);
    check("stall_count", bus.count, 3'd4);
    check("stall_in_ready", bus.in_ready, 1'b0);
    wait_sum_valid("stall");
    check("stall_sum", bus.sum, 40'h40014);
    check("stall_ovf", bus.ovf_flag, 1'b0);
    pat = 8'b01011001;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = pat[i];
      if (got < 4) begin
        check("stall_out_valid", bus.out_valid, 1'b1);
        check("stall_out_exp", bus.out_exp, 21'h018001 + 21'(got));
        check("stall_out_last", bus.out_last, (got == 3));
        check("stall_sum_valid", bus.sum_valid, 1'b1);
      end else begin
        check("stall_done_out_valid", bus.out_valid, 1'b0);
        check("stall_done_busy", bus.busy, 1'b0);
        check("stall_done_sum_valid", bus.sum_valid, 1'b0);
      end
      if (bus.out_valid === 1'b1 && pat[i]) got++;
      tick();
    end
    bus.out_ready = 1'b0;
    check("stall_received", got, 4);
    check("stall_sum_hold", bus.sum, 40'h40014);
    check("stall_count_hold", bus.count, 3'd4);
    model_add = 1'b0;

    // Truncation at MAX_N: six elements offered, no in_last
    accepted = 0;
    bus.in_valid = 1'b1;
    bus.in_x     = 17'h0;
    bus.in_last  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.in_ready === 1'b1) accepted++;
      if (i == 4) check("ovf_in_ready_low", bus.in_ready, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("ovf_accepted", accepted, 4);
    check("ovf_flag", bus.ovf_flag, 1'b1);
    check("ovf_count", bus.count, 3'd4);
    check("ovf_clamp", bus.clamp_flag, 1'b0);
    wait_sum_valid("ovf");
    check("ovf_sum", bus.sum, 40'h40000);
    drain("ovf", 4, 21'h018000);

    // Reset mid-issue with three elements outstanding
    send(17'h01000, 1'b0);
    send(17'h01000, 1'b0);
    send(17'h01000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_exp_x", bus.exp_x, 17'h0);
    check("mrst_sum", bus.sum, 40'h0);
    check("mrst_count", bus.count, 3'd0);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_out_valid", bus.out_valid, 1'b0);
    check("mrst_sum_valid", bus.sum_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(17'h00000, 1'b0);
    send(17'h00000, 1'b1);
    check("mrst_new_count", bus.count, 3'd2);
    wait_sum_valid("mrst");
    check("mrst_new_sum", bus.sum, 40'h20000);
    check("mrst_new_ovf", bus.ovf_flag, 1'b0);
    drain("mrst", 2, 21'h018000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
